// File: rtl/hovalaag_prog_loader_if.sv
// Host byte stream and program-memory write bus of the program loader.
interface hovalaag_prog_loader_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Host side: supplies bytes and observes the memory writes
    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    // Loader side: consumes bytes and drives the memory writes
    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/hovalaag_prog_loader.sv
// Program-store writer: turns a count/data/checksum byte stream into 256 x 32-bit
// program-memory writes, pads the tail with a fill word and gates the CPU reset.
module hovalaag_prog_loader #(
    parameter logic [31:0] FILL_WORD   = 32'h0000_8000,
    parameter bit          FILL_ENABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    hovalaag_prog_loader_if.slave bus,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ASM_W  = DATA_W - BYTE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_FILL,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   n_q, n_d;         // word count, 0 encodes 256
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [ASM_W-1:0]    word_q, word_d;   // first three bytes of the word in flight
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                busy_q, busy_d;
    logic                accept;

    // Byte acceptance: only while loading and never on a start cycle
    assign bus.in_ready = !start && (state_q inside {S_COUNT, S_DATA, S_CHECK});
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = wr_data_q;
    assign cpu_rst_n   = cpu_rst_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            addr_q      <= '0;
            bidx_q      <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            bidx_q      <= bidx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        addr_d      = addr_q;
        bidx_d      = bidx_q;
        word_d      = word_q;
        csum_d      = csum_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_rst_n_d = cpu_rst_n_q;

        // Word address advances after every write cycle (wraps past 255)
        if (wr_en_q) begin
            addr_d = ADDR_W'(addr_q + ADDR_W'(1));
        end

        if (start) begin
            state_d     = S_COUNT;
            addr_d      = '0;
            bidx_d      = '0;
            word_d      = '0;
            csum_d      = '0;
            done_d      = 1'b0;
            error_d     = 1'b0;
            cpu_rst_n_d = 1'b0;
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (accept) begin
                        n_d     = bus.in_data;
                        csum_d  = csum_q ^ bus.in_data;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum_d = csum_q ^ bus.in_data;
                        word_d = {word_q[ASM_W-BYTE_W-1:0], bus.in_data};
                        bidx_d = 2'(bidx_q + 2'd1);
                        if (bidx_q == 2'd3) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = {word_q, bus.in_data};
                            if (addr_q == ADDR_W'(n_q - BYTE_W'(1))) begin
                                state_d = S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        if (bus.in_data == csum_q) begin
                            if (FILL_ENABLE && (n_q != '0)) begin
                                state_d   = S_FILL;
                                wr_en_d   = 1'b1;
                                wr_data_d = FILL_WORD;
                            end else begin
                                state_d     = S_DONE;
                                done_d      = 1'b1;
                                cpu_rst_n_d = 1'b1;
                            end
                        end else begin
                            state_d = S_ERR;
                            error_d = 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (addr_q == '1) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        busy_d = state_d inside {S_COUNT, S_DATA, S_CHECK, S_FILL};
    end
endmodule
